// File: rtl/scan_decoder_pkg.sv
// -----------------------------------------------------------------------------
// scan_decoder_pkg
// Shared definitions for the scan decoder: mode encodings and a one-hot helper.
// onehot() works at the widest supported select (MAX_N bits); callers
// zero-extend their select and truncate the result to 2**N bits.
// -----------------------------------------------------------------------------
package scan_decoder_pkg;

  localparam int MAX_N = 8;
  localparam int MAX_W = 256;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Decode a select value into a single set bit at position sel.
  function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] sel);
    logic [MAX_W-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Counts 0..DIV-1 while run is high; tick is high combinationally during the
// cycle the count sits at DIV-1, so the owner steps on that edge.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset (count -> 0)
//   run   : advance the count this cycle
//   clear : force the count to 0 (wins over run)
//   tick  : terminal count reached while running
// -----------------------------------------------------------------------------
module scan_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int            PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TC = PW'(DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign tick = run && (cnt_q == TC);

  // Next count: clear dominates, terminal count rolls over, idle holds.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + PW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
// N-to-2**N one-hot decoder with registered output and a built-in scan
// sequencer. DECODE mode decodes sel_in; SCAN mode steps the select every DIV
// cycles and pulses wrap when it rolls over from 2**N-1 to 0.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset
//   en      : enable; low holds select/prescaler and blanks out/wrap
//   mode    : MODE_DECODE / MODE_SCAN
//   load    : SCAN only, load sel_in into the scan counter
//   sel_in  : external select or load value
//   out     : registered one-hot of cur_sel (zero while disabled/reset)
//   cur_sel : registered select currently decoded
//   wrap    : one-cycle pulse coincident with the wrap to 0
// -----------------------------------------------------------------------------
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int N   = 4,
  parameter int DIV = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              load,
  input  logic [N-1:0]      sel_in,
  output logic [(1<<N)-1:0] out,
  output logic [N-1:0]      cur_sel,
  output logic              wrap
);

  localparam int W = 1 << N;

  logic [N-1:0] sel_q;
  logic [N-1:0] sel_d;
  logic [W-1:0] out_q;
  logic [W-1:0] out_d;
  logic         wrap_q;
  logic         wrap_d;

  logic run_s;
  logic clear_s;
  logic tick_s;

  // Prescaler runs only in enabled SCAN; it is zeroed in DECODE and on load.
  assign run_s   = en && (mode == MODE_SCAN);
  assign clear_s = en && ((mode == MODE_DECODE) || load);

  scan_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run_s),
    .clear (clear_s),
    .tick  (tick_s)
  );

  // Next select and wrap; load beats a coincident terminal-count step.
  always_comb begin
    sel_d  = sel_q;
    wrap_d = 1'b0;
    if (!en) begin
      sel_d = sel_q;
    end else if ((mode == MODE_DECODE) || load) begin
      sel_d = sel_in;
    end else if (tick_s) begin
      sel_d  = sel_q + N'(1);
      wrap_d = &sel_q;
    end else begin
      sel_d = sel_q;
    end
  end

  // Output decodes the next select so out and cur_sel always agree.
  always_comb begin
    out_d = '0;
    if (en) begin
      out_d = W'(onehot(MAX_N'(sel_d)));
    end else begin
      out_d = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q  <= '0;
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out     = out_q;
  assign cur_sel = sel_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_scan_decoder
// Drives three builds (N=4/DIV=10, N=2/DIV=1, N=1/DIV=3) from shared inputs.
// A reference model pushes expected outputs at each drive; they are popped and
// compared after the edge. Directed sequences add fixed-value checks.
// -----------------------------------------------------------------------------
module tb_scan_decoder;
  import scan_decoder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, mode, load;
  logic [3:0] sel;

  logic [15:0] o4; logic [3:0] s4; logic w4;
  logic [3:0]  o2; logic [1:0] s2; logic w2;
  logic [1:0]  o1; logic       s1; logic w1;

  scan_decoder #(.N(4), .DIV(10)) d4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
    .sel_in(sel), .out(o4), .cur_sel(s4), .wrap(w4));
  scan_decoder #(.N(2), .DIV(1)) d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
    .sel_in(sel[1:0]), .out(o2), .cur_sel(s2), .wrap(w2));
  scan_decoder #(.N(1), .DIV(3)) d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
    .sel_in(sel[0:0]), .out(o1), .cur_sel(s1), .wrap(w1));

  typedef struct {
    logic [15:0] o4; logic [3:0] s4; logic w4;
    logic [3:0]  o2; logic [1:0] s2; logic w2;
    logic [1:0]  o1; logic       s1; logic w1;
  } exp_t;

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] exp_out;
  } vec_t;

  exp_t sb[$];
  int   msel[3];
  int   mpre[3];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model the next edge, push expectation, clock, then pop and compare.
  task automatic cycle();
    exp_t        e;
    logic [15:0] eo[3];
    logic        ew[3];
    for (int i = 0; i < 3; i++) begin
      int n;
      int dv;
      int md;
      int sin;
      n   = (i == 0) ? 4 : (i == 1) ? 2 : 1;
      dv  = (i == 0) ? 10 : (i == 1) ? 1 : 3;
      md  = 1 << n;
      sin = int'(sel) % md;
      ew[i] = 1'b0;
      eo[i] = 16'h0000;
      if (!rst_n) begin
        msel[i] = 0;
        mpre[i] = 0;
      end else if (en) begin
        if (!mode || load) begin
          msel[i] = sin;
          mpre[i] = 0;
        end else if (mpre[i] == dv - 1) begin
          mpre[i] = 0;
          msel[i] = msel[i] + 1;
          if (msel[i] == md) begin
            msel[i] = 0;
            ew[i]   = 1'b1;
          end
        end else begin
          mpre[i] = mpre[i] + 1;
        end
        eo[i] = 16'(onehot(8'(msel[i])));
      end
    end
    e.o4 = eo[0];       e.s4 = 4'(msel[0]); e.w4 = ew[0];
    e.o2 = 4'(eo[1]);   e.s2 = 2'(msel[1]); e.w2 = ew[1];
    e.o1 = 2'(eo[2]);   e.s1 = 1'(msel[2]); e.w1 = ew[2];
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_out4", 32'(o4), 32'(e.o4));
    chk("sb_sel4", 32'(s4), 32'(e.s4));
    chk("sb_wrap4", 32'(w4), 32'(e.w4));
    chk("sb_out2", 32'(o2), 32'(e.o2));
    chk("sb_sel2", 32'(s2), 32'(e.s2));
    chk("sb_wrap2", 32'(w2), 32'(e.w2));
    chk("sb_out1", 32'(o1), 32'(e.o1));
    chk("sb_sel1", 32'(s1), 32'(e.s1));
    chk("sb_wrap1", 32'(w1), 32'(e.w1));
    chk("onehot0_4", ($countones(o4) <= 1) ? 32'd1 : 32'd0, 32'd1);
    chk("onehot0_2", ($countones(o2) <= 1) ? 32'd1 : 32'd0, 32'd1);
    chk("onehot0_1", ($countones(o1) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    vec_t       tbl[16];
    logic [3:0] seq3[4];
    int         wraps;

    for (int k = 0; k < 16; k++) begin
      tbl[k].sel     = 4'(k);
      tbl[k].exp_out = 16'h0001 << k;
    end
    seq3[0] = 4'b0010; seq3[1] = 4'b0100; seq3[2] = 4'b1000; seq3[3] = 4'b0001;

    rst_n = 1'b0; en = 1'b0; mode = MODE_DECODE; load = 1'b0; sel = 4'd0;
    cycle(); cycle();
    chk("reset_out", 32'(o4), 32'd0);
    chk("reset_sel", 32'(s4), 32'd0);
    chk("reset_wrap", 32'(w4), 32'd0);

    // 1: DECODE sweep
    rst_n = 1'b1; en = 1'b1; mode = MODE_DECODE;
    for (int k = 0; k < 16; k++) begin
      sel = tbl[k].sel;
      cycle();
      chk("dec_out", 32'(o4), 32'(tbl[k].exp_out));
      chk("dec_wrap", 32'(w4), 32'd0);
    end

    // 2: SCAN from reset, full rotation
    rst_n = 1'b0; cycle();
    rst_n = 1'b1; mode = MODE_SCAN; sel = 4'd0; wraps = 0;
    for (int c = 1; c <= 161; c++) begin
      cycle();
      if (c <= 160 && w4) wraps++;
      if (c == 10)  chk("scan_first_step", 32'(s4), 32'd1);
      if (c == 159) chk("scan_pre_wrap", 32'(s4), 32'd15);
      if (c == 160) begin
        chk("scan_wrap_sel", 32'(s4), 32'd0);
        chk("scan_wrap_pulse", 32'(w4), 32'd1);
      end
      if (c == 161) chk("scan_wrap_end", 32'(w4), 32'd0);
    end
    chk("scan_wrap_count", 32'(wraps), 32'd1);

    // 3: DIV=1 build steps every cycle
    load = 1'b1; sel = 4'd0; cycle();
    chk("div1_load", 32'(o2), 32'(4'b0001));
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("div1_out", 32'(o2), 32'(seq3[i % 4]));
      chk("div1_wrap", 32'(w2), (i % 4 == 3) ? 32'd1 : 32'd0);
    end

    // 4: load coincident with terminal count at cur_sel=15
    load = 1'b1; sel = 4'd15; cycle();
    load = 1'b0;
    repeat (9) cycle();
    load = 1'b1; sel = 4'd13; cycle();
    chk("load_tc_sel", 32'(s4), 32'd13);
    chk("load_tc_nowrap", 32'(w4), 32'd0);
    load = 1'b0;
    repeat (9) cycle();
    chk("load_tc_hold", 32'(s4), 32'd13);
    cycle();
    chk("load_tc_next", 32'(s4), 32'd14);

    // 5: enable gap at cur_sel=5, prescaler=3
    load = 1'b1; sel = 4'd5; cycle();
    load = 1'b0;
    repeat (3) cycle();
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      chk("en_gap_out", 32'(o4), 32'd0);
      chk("en_gap_sel", 32'(s4), 32'd5);
    end
    en = 1'b1;
    repeat (6) cycle();
    chk("en_resume_sel", 32'(s4), 32'd5);
    chk("en_resume_out", 32'(o4), 32'h0020);
    cycle();
    chk("en_resume_step", 32'(s4), 32'd6);

    // 6: reset at cur_sel=15 with prescaler at terminal count
    load = 1'b1; sel = 4'd15; cycle();
    load = 1'b0;
    repeat (9) cycle();
    rst_n = 1'b0; cycle();
    chk("rst_tc_out", 32'(o4), 32'd0);
    chk("rst_tc_sel", 32'(s4), 32'd0);
    chk("rst_tc_wrap", 32'(w4), 32'd0);
    rst_n = 1'b1; cycle();
    chk("rst_after_sel", 32'(s4), 32'd0);
    chk("rst_after_wrap", 32'(w4), 32'd0);

    // Mode changes: DECODE->SCAN resumes from the decoded select
    mode = MODE_DECODE; sel = 4'd9; cycle();
    chk("mode_dec_sel", 32'(s4), 32'd9);
    mode = MODE_SCAN; sel = 4'd2;
    repeat (9) cycle();
    chk("mode_scan_hold", 32'(s4), 32'd9);
    cycle();
    chk("mode_scan_step", 32'(s4), 32'd10);

    // Random traffic checked by the scoreboard
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      en    = ($urandom_range(0, 7) != 0);
      mode  = ($urandom_range(0, 3) != 0);
      load  = ($urandom_range(0, 9) == 0);
      sel   = 4'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
